uart_rx_framed: RTL

8N1 UART receiver that pairs with the team's UART transmitter: same 8 data bits, LSB first, one start bit, one stop bit, same baud divisor. It sits on the serial input from the host/BLE link and delivers received command bytes to the command processor. It adds false-start rejection, framing-error reporting and overrun reporting.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync2.sv | 29 ++
 rtl/uart_rx_framed.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // 50 MHz / 19200 baud; the transmitter uses the same divisor.
  localparam logic [11:0] BAUD_DIV_DEFAULT = 12'hA2C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk cycles from i_async to o_sync.
// Backpressure: none; samples every cycle.
// Ports: clk, rst (sync, active-high), i_async (raw input), o_sync (synchronized output).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_framed.sv
// 8N1 UART receiver with false-start rejection, framing-error and overrun flags.
// Latency: rdy rises 3 + BAUD_DIV/2 + 9*BAUD_DIV cycles after the RX pin falls.
// Backpressure: none; a new byte overwrites rx_data and raises ovr if rdy was still set.
// Ports: clk, rst (sync, active-high), RX (async serial in, idle high),
//        clr_rdy (consumer ack), rx_data (last good byte), rdy (unread byte),
//        frm_err (sticky bad stop bit), ovr (sticky overrun), busy (frame in progress).
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = int'(BAUD_DIV_DEFAULT),
  parameter int CNT_W    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  input  logic                   clr_rdy,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rdy,
  output logic                   frm_err,
  output logic                   ovr,
  output logic                   busy
);

  // Start sample lands mid-bit: half a period after the detected edge.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [3:0]             r_bit_cnt;
  logic [3:0]             w_bit_nxt;
  logic [UART_DATA_W-1:0] r_shreg;
  logic [UART_DATA_W-1:0] w_shreg_nxt;
  logic [UART_DATA_W-1:0] r_rx_data;
  logic [UART_DATA_W-1:0] w_data_nxt;
  logic                   r_rdy;
  logic                   w_rdy_nxt;
  logic                   r_frm_err;
  logic                   w_frm_nxt;
  logic                   r_ovr;
  logic                   w_ovr_nxt;
  logic                   r_rx_q;
  logic                   w_rx_s;
  logic                   w_strobe;
  logic                   w_start_edge;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (RX),
    .o_sync  (w_rx_s)
  );

  // Only a fresh 1->0 transition starts a frame; a line held low does not retrigger.
  assign w_start_edge = r_rx_q & ~w_rx_s;
  assign w_strobe     = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr     <= 1'b0;
      r_rx_q    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shreg   <= w_shreg_nxt;
      r_rx_data <= w_data_nxt;
      r_rdy     <= w_rdy_nxt;
      r_frm_err <= w_frm_nxt;
      r_ovr     <= w_ovr_nxt;
      r_rx_q    <= w_rx_s;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_rx_data;
    w_rdy_nxt   = r_rdy;
    w_frm_nxt   = r_frm_err;
    w_ovr_nxt   = r_ovr;

    // Clear first so that any set event below in the same cycle wins.
    if (clr_rdy) begin
      w_rdy_nxt = 1'b0;
      w_frm_nxt = 1'b0;
      w_ovr_nxt = 1'b0;
    end

    // Counter and bit count hold while idle.
    if ((r_state != IDLE) && !w_strobe) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (w_strobe) begin
          if (!w_rx_s) begin
            w_state_nxt = DATA;
            w_cnt_nxt   = FULL_LOAD;
            w_bit_nxt   = '0;
          end else begin
            // Glitch shorter than half a bit: drop it silently.
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_strobe) begin
          w_shreg_nxt = {w_rx_s, r_shreg[UART_DATA_W-1:1]};
          w_bit_nxt   = r_bit_cnt + 4'd1;
          w_cnt_nxt   = FULL_LOAD;
          if (r_bit_cnt == 4'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // Leave at the stop-bit sample so a back-to-back start edge is caught.
        if (w_strobe) begin
          w_state_nxt = IDLE;
          if (w_rx_s) begin
            w_data_nxt = r_shreg;
            w_rdy_nxt  = 1'b1;
            if (r_rdy) begin
              w_ovr_nxt = 1'b1;
            end
          end else begin
            w_frm_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;
  assign ovr     = r_ovr;
  assign busy    = (r_state != IDLE);

endmodule
